second_tick_timer: RTL and testbench
====================================

# second_tick_timer

Consumes the slow one-second square wave produced by the design's clock divider and turns it into usable timing events for the traffic-light controller. It detects each rising edge of the wave as a one-second tick and runs a loadable down-counter of seconds for the current light phase. It pulses `done` when the phase time expires and raises `stall` if the second wave stops toggling. It sits between the second generator and the light-phase FSM.

## Interface
- `CNT_W`, default 7: width of the seconds counter; loads up to 2^CNT_W-1 s.
- `TIMEOUT`, default 16: clock cycles without any `sec_wave` edge before `stall` asserts; must exceed the generator's half period of 6 cycles.
- `TO_W`, default 5: width of the watchdog counter; must hold `TIMEOUT`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; 0 at a rising `clk` edge resets all state.
- `sec_wave` in 1: square wave from the second generator, synchronous to `clk`.
- `load` in 1: one-cycle request to start or restart a phase countdown.
- `load_val` in CNT_W: phase length in seconds, sampled when `load`=1.
- `pause` in 1: level; while 1, ticks do not decrement the count.
- `sec_tick` out 1: one-cycle pulse per rising edge of `sec_wave`.
- `remain` out CNT_W: seconds remaining in the current phase.
- `busy` out 1: 1 in RUN or HOLD.
- `done` out 1: one-cycle pulse when the countdown reaches 0.
- `stall` out 1: watchdog flag.

## Operation
- **Reset** (`reset`=0 at an edge) clears everything.
  - `sec_tick`=0, `remain`=0, `busy`=0, `done`=0, `stall`=0, state=IDLE.
  - `sec_d`=0, `primed`=0, watchdog count=0.
- **Edge detect**
  - `sec_d` registers `sec_wave` every cycle.
  - rise = `sec_wave` & ~`sec_d` & `primed`.
  - `primed` sets on the first edge after reset, so a high level at reset release is not a tick.
  - Any change = (`sec_wave` != `sec_d`) & `primed`.
- **States:** IDLE, RUN, HOLD.
- **IDLE**
  - `load` with `load_val`=0: `remain`=0, `done` pulses, stay IDLE.
  - `load` with `load_val`>0: `remain`=`load_val`; go to HOLD if `pause`=1, else RUN.
  - Rises in IDLE pulse `sec_tick` only.
- **RUN**
  - `load` has priority over everything; it reloads exactly as in IDLE, including the 0 case, which goes to IDLE.
  - Else if `pause`=1, go to HOLD; a rise in that same cycle is not counted.
  - Else on a rise, `remain` decrements by 1.
  - If `remain` was 1, it becomes 0, `done` pulses, and the state goes to IDLE.
- **HOLD**
  - `remain` is frozen.
  - `load` reloads as in IDLE.
  - `pause`=0 returns to RUN; a rise in that cycle is not counted.
- **`sec_tick`** pulses on every rise in every state, including a rise coincident with `load`. Such a rise is not applied to the newly loaded value.
- **`remain`** never wraps: no decrement below 0. Only `load` sets it nonzero.
- **Watchdog**
  - The counter clears on any `sec_wave` change, otherwise increments, saturating at `TIMEOUT`.
  - `stall`=1 while count==`TIMEOUT`; it clears in the cycle after the next change.
  - The watchdog is independent of state and inactive until `primed`.
- Reset mid-countdown aborts the phase with no `done` pulse.

## Timing
- All outputs are registered.
- `sec_tick`, the `remain` decrement and `done` are visible the cycle after the edge where the rise is sampled. `remain` goes to 0 in the same cycle as `done`.
- `load` at edge k: `remain`=`load_val` and `busy`=1 from cycle k+1.
- Period with the standard generator (half period 6): one tick every 12 cycles, so N seconds = N rises after load.
- `stall` rises exactly `TIMEOUT` cycles after the last change is sampled.
- `done` and `sec_tick` can assert in the same cycle.

## Test plan
- **Reset release:** reset low 3 cycles with `sec_wave`=1, then release → no `sec_tick`; the first tick comes on the next 0→1 transition; all outputs 0 until then.
- **Basic countdown:** 12-cycle wave, `load_val`=3 → `remain` 3→2→1→0 on three consecutive ticks; `done` pulses once with `remain`=0; `busy` falls the same cycle.
- **Pause:** `load_val`=5, `pause` high across two ticks → `remain` holds at its value and `sec_tick` still pulses; after release, 5 total counted ticks are needed for `done`.
- **Reload collisions:**
  - `load_val`=4 in the same cycle as a rise while RUN at `remain`=2 → `remain`=4 and `sec_tick`=1.
  - `load_val`=0 → `done` next cycle, `busy`=0.
- **Watchdog:** hold `sec_wave` constant → `stall`=1 exactly 16 cycles after the last edge; resume toggling → `stall`=0 one cycle after the first edge.
- **Reset mid-phase:** reset at `remain`=2 → `remain`=0, `busy`=0, no `done`.

Source files
------------

// File: rtl/second_tick_timer.sv
// Turns the one-second square wave into tick pulses, runs a loadable seconds
// countdown for the current light phase, and watches the wave for a stall.
//
// state | meaning
// IDLE  | no phase running; ticks only pulse sec_tick
// RUN   | counting down one second per tick
// HOLD  | phase loaded but frozen while pause is high
module second_tick_timer #(
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sec_wave,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             pause,
  output logic             sec_tick,
  output logic [CNT_W-1:0] remain,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic            sec_d;
  logic            primed;
  logic [TO_W-1:0] wd_cnt;
  logic [TO_W-1:0] wd_nxt;
  logic            rise;
  logic            change;

  // primed masks the reset value of sec_d so a wave already high is not a tick
  assign rise   = sec_wave & ~sec_d & primed;
  assign change = (sec_wave != sec_d) & primed;

  always_comb begin
    wd_nxt = wd_cnt;
    if (change)
      wd_nxt = '0;
    else if (wd_cnt != TO_W'(TIMEOUT))
      wd_nxt = wd_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      sec_d    <= 1'b0;
      primed   <= 1'b0;
      wd_cnt   <= '0;
      sec_tick <= 1'b0;
      remain   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stall    <= 1'b0;
    end else begin
      sec_d    <= sec_wave;
      primed   <= 1'b1;
      sec_tick <= rise;
      done     <= 1'b0;

      if (primed) begin
        wd_cnt <= wd_nxt;
        stall  <= (wd_nxt == TO_W'(TIMEOUT));
      end

      // load wins in every state; a coincident rise is not applied to the new value
      if (load) begin
        if (load_val == '0) begin
          remain <= '0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end else begin
          remain <= load_val;
          busy   <= 1'b1;
          state  <= pause ? HOLD : RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (rise) begin
              remain <= remain - CNT_W'(1);
              if (remain == CNT_W'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          HOLD: begin
            if (!pause)
              state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_second_tick_timer.sv
// Randomized and directed stimulus for second_tick_timer, compared every cycle
// against a phase/second-count model built from the timer's behavioural rules.
module tb_second_tick_timer;

  localparam int CNT_W   = 7;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sec_wave = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             pause = 1'b0;
  logic             sec_tick;
  logic [CNT_W-1:0] remain;
  logic             busy;
  logic             done;
  logic             stall;

  second_tick_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .sec_wave(sec_wave), .load(load),
    .load_val(load_val), .pause(pause), .sec_tick(sec_tick),
    .remain(remain), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // reference model: seconds left in the phase, whether a phase is live,
  // whether it is frozen, and how long the wave has been quiet
  int m_left = 0, m_quiet = 0;
  bit m_prev = 0, m_seen = 0, m_live = 0, m_frozen = 0;
  bit e_tick = 0, e_done = 0, e_stall = 0;

  task automatic model_step();
    bit r, ch;
    if (!reset) begin
      m_left = 0; m_quiet = 0; m_prev = 0; m_seen = 0;
      m_live = 0; m_frozen = 0; e_tick = 0; e_done = 0; e_stall = 0;
      return;
    end
    r  = m_seen && sec_wave && !m_prev;
    ch = m_seen && (sec_wave != m_prev);
    e_tick = r;
    e_done = 0;
    if (load) begin
      if (load_val == 0) begin
        m_left = 0; e_done = 1; m_live = 0; m_frozen = 0;
      end else begin
        m_left = load_val; m_live = 1; m_frozen = pause;
      end
    end else if (m_live && !m_frozen) begin
      if (pause) m_frozen = 1;
      else if (r && m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin e_done = 1; m_live = 0; end
      end
    end else if (m_live && m_frozen) begin
      if (!pause) m_frozen = 0;
    end
    if (m_seen) begin
      if (ch) m_quiet = 0;
      else if (m_quiet < TIMEOUT) m_quiet = m_quiet + 1;
      e_stall = (m_quiet == TIMEOUT);
    end
    m_prev = sec_wave;
    m_seen = 1;
  endtask

  // bench-side second generator
  int  hp = 6, gcnt = 0;
  bit  frozen = 0;
  bit  collide = 0;
  bit  collided = 0;

  task automatic step();
    if (!frozen) begin
      gcnt++;
      if (gcnt >= hp) begin sec_wave = ~sec_wave; gcnt = 0; end
    end
    if (collide && m_live && !m_frozen && m_left == 2 && sec_wave && !m_prev) begin
      load = 1; load_val = 4; collide = 0; collided = 1;
    end
    @(posedge clk);
    model_step();
    #1;
    chk("sec_tick", int'(sec_tick), int'(e_tick));
    chk("remain",   int'(remain),   m_left);
    chk("busy",     int'(busy),     int'(m_live));
    chk("done",     int'(done),     int'(e_done));
    chk("stall",    int'(stall),    int'(e_stall));
    load = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset release with the wave already high
    reset = 0; sec_wave = 1; frozen = 1;
    run(3);
    reset = 1;
    run(4);
    frozen = 0; gcnt = 0;
    run(20);

    // basic countdown of 3 s
    load = 1; load_val = 3;
    run(45);

    // 5 s phase paused across two ticks
    load = 1; load_val = 5;
    run(15);
    pause = 1;
    run(30);
    pause = 0;
    run(60);

    // reload 4 on a rise while running at 2
    load = 1; load_val = 3;
    collide = 1;
    for (int i = 0; i < 100 && collide; i++) step();
    chk("collision_hit", int'(collided), 1);
    collide = 0;
    run(3);
    chk("collision_remain", int'(remain), 4);
    run(10);

    // zero-length phase
    load = 1; load_val = 0;
    run(3);

    // watchdog: stop the wave, then resume
    frozen = 1;
    run(30);
    frozen = 0;
    run(30);

    // reset mid-phase
    load = 1; load_val = 5;
    for (int i = 0; i < 100 && !(m_live && m_left == 2); i++) step();
    chk("midphase_reached", m_left, 2);
    reset = 0;
    run(1);
    reset = 1;
    run(20);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) hp = $urandom_range(3, 9);
      if (!frozen && $urandom_range(0, 299) == 0) frozen = 1;
      else if (frozen && $urandom_range(0, 24) == 0) frozen = 0;
      if ($urandom_range(0, 39) == 0) begin
        load = 1; load_val = CNT_W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      reset = ($urandom_range(0, 599) != 0);
      step();
    end
    reset = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
